// File: rtl/ccx_ic_arbiter_if.sv
// Core-side memory bus: request channel plus a one-cycle-late response.
// Latency: none (plain wires).
// Backpressure: the responder holds off a request by keeping gnt low while req is high.
interface core_mem_bus #(
  parameter int AW = 39,
  parameter int DW = 64
);
  logic            req;
  logic            gnt;
  logic            wen;
  logic [DW/8-1:0] strb;
  logic [AW-1:0]   addr;
  logic [DW-1:0]   wdata;
  logic [DW-1:0]   rdata;
  logic            err;

  // Requestor side: drives the request, receives the grant and response.
  modport REQ (output req, wen, strb, addr, wdata, input gnt, rdata, err);
  // Responder side: receives the request, drives the grant and response.
  modport RSP (input req, wen, strb, addr, wdata, output gnt, rdata, err);
endinterface

// File: rtl/ccx_ic_arbiter.sv
// Merges the instruction-fetch and data buses onto one core-side bus; data wins unless fetch is starved.
// Latency: zero cycles from request to out, one cycle for the response to return to the issuing port.
// Backpressure: an un-granted request locks the selection until accepted; the other port waits with gnt=0.
module ccx_ic_arbiter #(
  parameter int AW           = 39,
  parameter int DW           = 64,
  parameter int STARVE_LIMIT = 4
) (
  input logic       g_clk,
  input logic       g_resetn,
  core_mem_bus.RSP  if_imem,
  core_mem_bus.RSP  if_dmem,
  core_mem_bus.REQ  if_out
);

  localparam int            CW    = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  localparam logic SEL_IMEM = 1'b0;
  localparam logic SEL_DMEM = 1'b1;

  logic          lock;
  logic          lock_sel;
  logic [CW-1:0] starve_cnt;
  logic          rsp_imem;
  logic          rsp_dmem;

  logic sel;
  logic starved;
  logic accept;
  logic imem_acc;

  // Pick the port that owns the merged bus this cycle.
  always_comb begin
    sel     = SEL_IMEM;
    starved = if_imem.req && (starve_cnt >= LIMIT);
    if (lock) begin
      sel = lock_sel;
    end else if (if_dmem.req && !starved) begin
      sel = SEL_DMEM;
    end
  end

  // Request pass-through; imem fields sit on the bus when nobody requests.
  assign if_out.req   = (sel == SEL_DMEM) ? if_dmem.req   : if_imem.req;
  assign if_out.wen   = (sel == SEL_DMEM) ? if_dmem.wen   : if_imem.wen;
  assign if_out.strb  = (sel == SEL_DMEM) ? if_dmem.strb  : if_imem.strb;
  assign if_out.addr  = (sel == SEL_DMEM) ? if_dmem.addr  : if_imem.addr;
  assign if_out.wdata = (sel == SEL_DMEM) ? if_dmem.wdata : if_imem.wdata;

  // Grants only reach the selected port, and only while it is requesting.
  assign if_imem.gnt = (sel == SEL_IMEM) && if_imem.req && if_out.gnt;
  assign if_dmem.gnt = (sel == SEL_DMEM) && if_dmem.req && if_out.gnt;

  assign accept   = if_out.req && if_out.gnt;
  assign imem_acc = if_imem.req && if_imem.gnt;

  // Responses are steered by the route captured at acceptance.
  assign if_imem.rdata = rsp_imem ? if_out.rdata : '0;
  assign if_imem.err   = rsp_imem ? if_out.err   : 1'b0;
  assign if_dmem.rdata = rsp_dmem ? if_out.rdata : '0;
  assign if_dmem.err   = rsp_dmem ? if_out.err   : 1'b0;

  // Lock holds a stalled request; it falls on acceptance or when the owner drops req (out.req goes low).
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      lock     <= 1'b0;
      lock_sel <= SEL_IMEM;
    end else if (if_out.req && !if_out.gnt) begin
      lock     <= 1'b1;
      lock_sel <= sel;
    end else begin
      lock     <= 1'b0;
    end
  end

  // Count consecutive cycles of un-served fetch requests, saturating at the limit.
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      starve_cnt <= '0;
    end else if (if_imem.req && !imem_acc) begin
      if (starve_cnt != LIMIT) begin
        starve_cnt <= starve_cnt + CW'(1);
      end
    end else begin
      starve_cnt <= '0;
    end
  end

  // Remember which port owns next cycle's response.
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      rsp_imem <= 1'b0;
      rsp_dmem <= 1'b0;
    end else begin
      rsp_imem <= accept && (sel == SEL_IMEM);
      rsp_dmem <= accept && (sel == SEL_DMEM);
    end
  end

endmodule
